// File: rtl/casez_match_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : casez_match_sequencer
// Description : Sequential wildcard-match scheduler. It holds a small table of
//               (value, don't-care mask, enable) labels and scans them one
//               entry per cycle, lowest index first, against an accepted key.
//               The first matching entry wins. The result is returned over a
//               valid/ready handshake. On a miss, res_idx keeps its previous
//               value.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk           rising-edge clock
//   reset         asynchronous, active-high; clears FSM and table
//   i_cfg_we      table write strobe
//   i_cfg_idx     entry to write
//   i_cfg_value   label value
//   i_cfg_mask    label don't-care bits (1 = ignore)
//   i_cfg_en      entry enable written with the entry
//   i_key_valid   key offered
//   o_key_ready   key accepted when valid && ready (IDLE only)
//   i_key         key value
//   i_key_dc      key don't-care bits (1 = ignore)
//   o_res_valid   result available
//   i_res_ready   result consumed when valid && ready
//   o_res_hit     1 = an entry matched
//   o_res_idx     index of the matching entry; held on a miss
//   o_busy        high while a key is being scanned or its result is pending
// ============================================================================
module casez_match_sequencer #(
  parameter int WIDTH   = 5,
  parameter int ENTRIES = 4,
  parameter int IDXW    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_cfg_we,
  input  logic [IDXW-1:0]  i_cfg_idx,
  input  logic [WIDTH-1:0] i_cfg_value,
  input  logic [WIDTH-1:0] i_cfg_mask,
  input  logic             i_cfg_en,
  input  logic             i_key_valid,
  output logic             o_key_ready,
  input  logic [WIDTH-1:0] i_key,
  input  logic [WIDTH-1:0] i_key_dc,
  output logic             o_res_valid,
  input  logic             i_res_ready,
  output logic             o_res_hit,
  output logic [IDXW-1:0]  o_res_idx,
  output logic             o_busy
);

  localparam logic [IDXW-1:0] C_LAST_IDX = IDXW'(ENTRIES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t           r_state;
  logic [IDXW-1:0]  r_scan_idx;
  logic [WIDTH-1:0] r_key;
  logic [WIDTH-1:0] r_key_dc;

  logic [WIDTH-1:0] r_value [ENTRIES];
  logic [WIDTH-1:0] r_mask  [ENTRIES];
  logic [ENTRIES-1:0] r_en;

  logic [WIDTH-1:0] w_care;
  logic             w_match;

  // --------------------------------------------------------------------------
  // Label table. Writes land on the clock edge, so the entry compared in the
  // same cycle as a write still uses its old contents, while entries scanned
  // later observe the new ones.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_value[i] <= '0;
        r_mask[i]  <= '0;
      end
      r_en <= '0;
    end else if (i_cfg_we) begin
      r_value[i_cfg_idx] <= i_cfg_value;
      r_mask[i_cfg_idx]  <= i_cfg_mask;
      r_en[i_cfg_idx]    <= i_cfg_en;
    end
  end

  // A bit participates in the compare only if neither the label nor the key
  // marks it as don't-care.
  assign w_care  = ~(r_mask[r_scan_idx] | r_key_dc);
  assign w_match = r_en[r_scan_idx] &
                   (((r_key ^ r_value[r_scan_idx]) & w_care) == '0);

  // --------------------------------------------------------------------------
  // Control FSM with registered outputs.
  // The decision edge loads res_hit/res_idx and enters RESP; res_valid rises
  // one edge later, so the presented result comes straight from stable
  // registers. A hit on entry i is therefore visible after edge i+2.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_scan_idx  <= '0;
      r_key       <= '0;
      r_key_dc    <= '0;
      o_key_ready <= 1'b1;
      o_res_valid <= 1'b0;
      o_res_hit   <= 1'b0;
      o_res_idx   <= '0;
      o_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // key_ready is high throughout IDLE, so valid alone is an accept.
          if (i_key_valid) begin
            r_key       <= i_key;
            r_key_dc    <= i_key_dc;
            r_scan_idx  <= '0;
            o_key_ready <= 1'b0;
            o_busy      <= 1'b1;
            r_state     <= ST_SCAN;
          end
        end

        ST_SCAN: begin
          if (w_match) begin
            o_res_hit <= 1'b1;
            o_res_idx <= r_scan_idx;
            r_state   <= ST_RESP;
          end else if (r_scan_idx == C_LAST_IDX) begin
            // Miss: index deliberately left untouched.
            o_res_hit <= 1'b0;
            r_state   <= ST_RESP;
          end else begin
            r_scan_idx <= r_scan_idx + IDXW'(1);
          end
        end

        ST_RESP: begin
          if (!o_res_valid) begin
            o_res_valid <= 1'b1;
          end else if (i_res_ready) begin
            o_res_valid <= 1'b0;
            o_key_ready <= 1'b1;
            o_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_casez_match_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_casez_match_sequencer
// Description : Scoreboard bench for casez_match_sequencer. The driver issues
//               keys and table writes, predicting each result from a
//               first-match table model; a monitor pops and compares results
//               as the DUT presents them, applying random backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_casez_match_sequencer;

  localparam int WIDTH   = 5;
  localparam int ENTRIES = 4;
  localparam int IDXW    = 2;

  logic             clk;
  logic             reset;
  logic             i_cfg_we;
  logic [IDXW-1:0]  i_cfg_idx;
  logic [WIDTH-1:0] i_cfg_value;
  logic [WIDTH-1:0] i_cfg_mask;
  logic             i_cfg_en;
  logic             i_key_valid;
  logic             o_key_ready;
  logic [WIDTH-1:0] i_key;
  logic [WIDTH-1:0] i_key_dc;
  logic             o_res_valid;
  logic             i_res_ready;
  logic             o_res_hit;
  logic [IDXW-1:0]  o_res_idx;
  logic             o_busy;

  casez_match_sequencer #(
    .WIDTH  (WIDTH),
    .ENTRIES(ENTRIES),
    .IDXW   (IDXW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .i_cfg_we   (i_cfg_we),
    .i_cfg_idx  (i_cfg_idx),
    .i_cfg_value(i_cfg_value),
    .i_cfg_mask (i_cfg_mask),
    .i_cfg_en   (i_cfg_en),
    .i_key_valid(i_key_valid),
    .o_key_ready(o_key_ready),
    .i_key      (i_key),
    .i_key_dc   (i_key_dc),
    .o_res_valid(o_res_valid),
    .i_res_ready(i_res_ready),
    .o_res_hit  (o_res_hit),
    .o_res_idx  (o_res_idx),
    .o_busy     (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Number of rising edges seen so far.
  int cyc = 0;
  always @(posedge clk) cyc++;

  // --------------------------------------------------------------------------
  // Reference model: the table as plain arrays plus the last reported index.
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] m_val  [ENTRIES];
  logic [WIDTH-1:0] m_mask [ENTRIES];
  bit               m_en   [ENTRIES];
  int               m_last_idx;

  typedef struct {
    bit hit;
    int idx;
    int acc;   // edge number at which the key is accepted
    int lat;   // edges from accept to res_valid high
  } exp_t;

  exp_t sb_q[$];

  int vectors  = 0;
  int errors   = 0;
  int issued   = 0;
  int done_cnt = 0;
  bit force_stall = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < ENTRIES; i++) begin
      m_val[i]  = '0;
      m_mask[i] = '0;
      m_en[i]   = 1'b0;
    end
    m_last_idx = 0;
  endtask

  // First enabled entry whose cared-about bits equal the key wins.
  function automatic exp_t model_lookup(input logic [WIDTH-1:0] k,
                                        input logic [WIDTH-1:0] kdc,
                                        input int acc);
    exp_t e;
    e.hit = 1'b0;
    e.idx = m_last_idx;
    e.acc = acc;
    e.lat = ENTRIES + 1;
    for (int i = 0; i < ENTRIES; i++) begin
      if (m_en[i] && (((k ^ m_val[i]) & ~(m_mask[i] | kdc)) == '0)) begin
        e.hit = 1'b1;
        e.idx = i;
        e.lat = i + 2;
        m_last_idx = i;
        break;
      end
    end
    return e;
  endfunction

  task automatic cfg_write(input int idx, input logic [WIDTH-1:0] v,
                           input logic [WIDTH-1:0] m, input bit en);
    @(negedge clk);
    i_cfg_we    = 1'b1;
    i_cfg_idx   = IDXW'(idx);
    i_cfg_value = v;
    i_cfg_mask  = m;
    i_cfg_en    = en;
    m_val[idx]  = v;
    m_mask[idx] = m;
    m_en[idx]   = en;
    @(negedge clk);
    i_cfg_we    = 1'b0;
  endtask

  task automatic wait_key_ready();
    int n;
    n = 0;
    while (!o_key_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!o_key_ready) begin
      errors++;
      vectors++;
      $display("FAIL key_ready_timeout: key_ready=%0b, expected 1", o_key_ready);
    end
  endtask

  task automatic send_key(input logic [WIDTH-1:0] k, input logic [WIDTH-1:0] kdc);
    int n;
    @(negedge clk);
    wait_key_ready();
    i_key_valid = 1'b1;
    i_key       = k;
    i_key_dc    = kdc;
    sb_q.push_back(model_lookup(k, kdc, cyc + 1));
    issued++;
    @(negedge clk);
    i_key_valid = 1'b0;
    check("key_ready_after_accept", int'(o_key_ready), 0);
    check("busy_after_accept", int'(o_busy), 1);
    n = 0;
    while (done_cnt != issued && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt != issued) begin
      errors++;
      vectors++;
      $display("FAIL result_timeout: results=%0d, expected %0d", done_cnt, issued);
      sb_q.delete();
      done_cnt = issued;
    end
  endtask

  // --------------------------------------------------------------------------
  // Monitor: drives res_ready, checks hold behaviour under backpressure and
  // pops the scoreboard on the cycle whose edge completes the handshake.
  // --------------------------------------------------------------------------
  bit   in_resp    = 1'b0;
  bit   hs_pending = 1'b0;
  int   first_cyc;
  int   stall;
  logic hold_hit;
  logic [IDXW-1:0] hold_idx;

  always @(negedge clk) begin
    if (reset) begin
      in_resp     = 1'b0;
      hs_pending  = 1'b0;
      i_res_ready = 1'b0;
    end else if (hs_pending) begin
      hs_pending  = 1'b0;
      in_resp     = 1'b0;
      i_res_ready = 1'b0;
      check("res_valid_drop", int'(o_res_valid), 0);
      check("key_ready_after_hs", int'(o_key_ready), 1);
    end else if (o_res_valid) begin
      if (!in_resp) begin
        in_resp   = 1'b1;
        first_cyc = cyc;
        hold_hit  = o_res_hit;
        hold_idx  = o_res_idx;
        stall     = force_stall ? 3 : int'($urandom_range(0, 2));
        force_stall = 1'b0;
      end else begin
        check("hold_res_hit", int'(o_res_hit), int'(hold_hit));
        check("hold_res_idx", int'(o_res_idx), int'(hold_idx));
        check("hold_key_ready", int'(o_key_ready), 0);
        check("hold_busy", int'(o_busy), 1);
      end
      if (stall > 0) begin
        stall--;
        i_res_ready = 1'b0;
      end else begin
        i_res_ready = 1'b1;
        hs_pending  = 1'b1;
        if (sb_q.size() == 0) begin
          errors++;
          vectors++;
          $display("FAIL unexpected_result: hit=%0b idx=%0d, expected none",
                   o_res_hit, o_res_idx);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("res_hit", int'(o_res_hit), int'(e.hit));
          check("res_idx", int'(o_res_idx), e.idx);
          check("latency", first_cyc - e.acc, e.lat);
          done_cnt++;
        end
      end
    end else begin
      i_res_ready = 1'b0;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    reset       = 1'b1;
    i_cfg_we    = 1'b0;
    i_cfg_idx   = '0;
    i_cfg_value = '0;
    i_cfg_mask  = '0;
    i_cfg_en    = 1'b0;
    i_key_valid = 1'b0;
    i_key       = '0;
    i_key_dc    = '0;
    i_res_ready = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);

    check("reset_key_ready", int'(o_key_ready), 1);
    check("reset_res_valid", int'(o_res_valid), 0);
    check("reset_res_hit",   int'(o_res_hit), 0);
    check("reset_res_idx",   int'(o_res_idx), 0);
    check("reset_busy",      int'(o_busy), 0);
    reset = 1'b0;

    // Base table
    cfg_write(0, 5'b00000, 5'b00001, 1'b1);
    cfg_write(1, 5'b00100, 5'b00010, 1'b1);
    cfg_write(2, 5'b01000, 5'b00110, 1'b1);

    send_key(5'b00001, 5'b00000);   // hit e0
    send_key(5'b00110, 5'b00000);   // hit e1
    send_key(5'b10000, 5'b00000);   // miss, idx held at 1
    send_key(5'b11000, 5'b10000);   // hit e2 via key don't-care
    send_key(5'b11000, 5'b00000);   // miss, idx held at 2

    // Catch-all on the last entry must not steal priority.
    cfg_write(3, 5'b00000, 5'b11111, 1'b1);
    send_key(5'b00001, 5'b00000);   // e0
    force_stall = 1'b1;             // three cycles of backpressure
    send_key(5'b10101, 5'b00000);   // e3

    // Disabled catch-all never matches.
    cfg_write(3, 5'b00000, 5'b11111, 1'b0);
    send_key(5'b10101, 5'b00000);

    // Randomized traffic
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        cfg_write(int'($urandom_range(0, ENTRIES - 1)),
                  WIDTH'($urandom),
                  WIDTH'($urandom & $urandom),
                  $urandom_range(0, 3) != 0);
      end
      send_key(WIDTH'($urandom), WIDTH'($urandom & $urandom & $urandom));
    end

    // Reset in the middle of a scan: no result, table cleared.
    @(negedge clk);
    wait_key_ready();
    i_key_valid = 1'b1;
    i_key       = 5'b00110;
    i_key_dc    = 5'b00000;
    @(posedge clk);                 // accept edge
    @(negedge clk);
    i_key_valid = 1'b0;
    @(posedge clk);                 // edge 1
    #2 reset = 1'b1;
    #1;
    check("midscan_res_valid", int'(o_res_valid), 0);
    check("midscan_res_hit",   int'(o_res_hit), 0);
    check("midscan_res_idx",   int'(o_res_idx), 0);
    check("midscan_busy",      int'(o_busy), 0);
    check("midscan_key_ready", int'(o_key_ready), 1);
    model_clear();
    @(negedge clk);
    reset = 1'b0;
    send_key(5'b00001, 5'b00000);   // cleared table: miss, idx 0

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
